// File: rtl/mux_n_to_1_stream_if.sv
// Stream bundle between N producer channels and one consumer, plus mux control/status.
// The master side drives producers/consumer; the slave side is the multiplexer.
interface mux_n_to_1_stream_if #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic                   mode;
  logic [SEL_W-1:0]       sel;
  logic [N_CH-1:0]        in_valid;
  logic [N_CH-1:0]        in_ready;
  logic [N_CH*DATA_W-1:0] in_data;
  logic [N_CH-1:0]        in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_W-1:0]      out_data;
  logic                   out_last;
  logic [SEL_W-1:0]       out_ch;
  logic                   busy;

  modport master (
    output mode, sel, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_ch, busy
  );

  modport slave (
    input  mode, sel, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_ch, busy
  );
endinterface

// File: rtl/mux_n_to_1_stream.sv
// N-to-1 stream multiplexer: fixed-select or round-robin arbitration, grant held
// for a whole packet, single registered output stage.
//
// state  | meaning
// IDLE   | no packet open; grant decided combinationally from mode/sel/rr_ptr
// LOCKED | packet open on lock_ch; grant pinned until its last beat
module mux_n_to_1_stream #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mux_n_to_1_stream_if.slave        bus
);
  localparam int SEL_W = $clog2(N_CH);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;

  logic              load_ok;
  logic              grant_vld;
  logic [SEL_W-1:0]  grant_ch;
  logic [N_CH-1:0]   ready;
  logic              xfer;
  logic [DATA_W-1:0] beat_data;
  logic              beat_last;

  // in_ready is held low while reset is asserted so no beat is consumed and lost
  assign load_ok = rst_n && (!out_valid_q || bus.out_ready);

  always_comb begin : grant_logic
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_ch  = '0;
    if (state_q == LOCKED) begin
      grant_vld = 1'b1;
      grant_ch  = lock_ch_q;
    end else if (!bus.mode) begin
      if (int'(bus.sel) < N_CH) begin
        grant_vld = 1'b1;
        grant_ch  = bus.sel;
      end
    end else begin
      // scan farthest-first so the channel nearest after rr_ptr wins
      for (int i = N_CH; i >= 1; i--) begin
        idx = (int'(rr_ptr_q) + i) % N_CH;
        if (bus.in_valid[idx[SEL_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_ch  = idx[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    if (grant_vld && load_ok) ready[grant_ch] = 1'b1;
  end

  assign xfer      = |(ready & bus.in_valid);
  assign beat_data = bus.in_data[grant_ch*DATA_W +: DATA_W];
  assign beat_last = bus.in_last[grant_ch];

  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (load_ok) begin
      out_valid_d = xfer;
      if (xfer) begin
        out_data_d = beat_data;
        out_last_d = beat_last;
        out_ch_d   = grant_ch;
      end
    end
    if (xfer) begin
      if (beat_last) begin
        state_d  = IDLE;
        rr_ptr_d = grant_ch;
      end else if (state_q == IDLE) begin
        state_d   = LOCKED;
        lock_ch_d = grant_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lock_ch_q   <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.busy      = (state_q == LOCKED);
endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// Directed bench for mux_n_to_1_stream: per-channel beat queues feed the inputs,
// expected output beats go to a scoreboard queue checked by a separate monitor.
module tb_mux_n_to_1_stream;
  localparam int N_CH   = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst_n;

  mux_n_to_1_stream_if #(.N_CH(N_CH), .DATA_W(DATA_W)) bus ();

  mux_n_to_1_stream #(.N_CH(N_CH), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] bd [N_CH][DEPTH];
  logic       bl [N_CH][DEPTH];
  int         rd [N_CH];
  int         wr [N_CH];
  logic [3:0] fire_neg;
  logic [10:0] expq [$];

  task automatic drive();
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    v = '0; l = '0; d = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (rd[k] != wr[k]) begin
        v[k] = 1'b1;
        l[k] = bl[k][rd[k]];
        d[k*8 +: 8] = bd[k][rd[k]];
      end
    end
    bus.in_valid = v;
    bus.in_last  = l;
    bus.in_data  = d;
  endtask

  task automatic push_beat(input int k, input logic [7:0] d, input logic l);
    bd[k][wr[k]] = d;
    bl[k][wr[k]] = l;
    wr[k]++;
    drive();
  endtask

  task automatic clear_ch(input int k);
    rd[k] = wr[k];
    drive();
  endtask

  task automatic expect_beat(input logic [1:0] ch, input logic l, input logic [7:0] d);
    expq.push_back({ch, l, d});
  endtask

  // one clock; inputs change just after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    for (int k = 0; k < N_CH; k++) if (fire_neg[k]) rd[k]++;
    drive();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_done(input string name, input int max);
    int c;
    c = 0;
    while (expq.size() != 0 && c < max) begin
      tick();
      c++;
    end
    n_cmp++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL %s: %0d beats outstanding after %0d cycles, required 0", name, expq.size(), c);
    end
  endtask

  // monitor: samples on the falling edge, pops one expected beat per output transfer
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clk);
      fire_neg = bus.in_valid & bus.in_ready;
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL mon_extra: got ch%0d data %02h last %0d, required no beat",
                   bus.out_ch, bus.out_data, bus.out_last);
        end else begin
          e = expq.pop_front();
          if ({bus.out_ch, bus.out_last, bus.out_data} !== e) begin
            n_err++;
            $display("FAIL mon_beat: got ch%0d data %02h last %0d, required ch%0d data %02h last %0d",
                     bus.out_ch, bus.out_data, bus.out_last, e[10:9], e[7:0], e[8]);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fire_neg = '0;
    for (int k = 0; k < N_CH; k++) begin rd[k] = 0; wr[k] = 0; end
    rst_n         = 1'b0;
    bus.mode      = 1'b1;
    bus.sel       = '0;
    bus.out_ready = 1'b1;
    drive();

    // 1: reset with all channels valid, then round-robin over single-beat packets
    push_beat(0, 8'h10, 1'b1);
    push_beat(0, 8'h14, 1'b1);
    push_beat(1, 8'h11, 1'b1);
    push_beat(2, 8'h12, 1'b1);
    push_beat(3, 8'h13, 1'b1);
    @(negedge clk);
    chk("rst_in_valid", 32'(bus.in_valid), 32'hF);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_out_last", 32'(bus.out_last), 32'h0);
    chk("rst_out_ch", 32'(bus.out_ch), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    expect_beat(2'd0, 1'b1, 8'h10);
    expect_beat(2'd1, 1'b1, 8'h11);
    expect_beat(2'd2, 1'b1, 8'h12);
    expect_beat(2'd3, 1'b1, 8'h13);
    expect_beat(2'd0, 1'b1, 8'h14);
    wait_done("rr_seq", 40);

    // 2: fixed select of ch2 with every channel valid
    bus.mode = 1'b0;
    bus.sel  = 2'd2;
    push_beat(0, 8'h20, 1'b1);
    push_beat(1, 8'h21, 1'b1);
    push_beat(2, 8'hA5, 1'b1);
    push_beat(3, 8'h23, 1'b1);
    expect_beat(2'd2, 1'b1, 8'hA5);
    @(negedge clk);
    chk("fix_in_ready", 32'(bus.in_ready), 32'h4);
    tick();
    @(negedge clk);
    chk("fix_out_valid", 32'(bus.out_valid), 32'h1);
    chk("fix_out_data", 32'(bus.out_data), 32'hA5);
    chk("fix_out_ch", 32'(bus.out_ch), 32'h2);
    tick();
    chk("fix_others_held", 32'(bus.in_valid), 32'hB);
    clear_ch(0); clear_ch(1); clear_ch(3);
    wait_done("fix_drain", 20);

    // 3: ch1 three-beat packet locks out ch0/ch2; rr_ptr first parked at ch0
    bus.mode = 1'b1;
    push_beat(0, 8'h30, 1'b1);
    expect_beat(2'd0, 1'b1, 8'h30);
    wait_done("park_rr", 20);
    push_beat(1, 8'h31, 1'b0);
    push_beat(1, 8'h32, 1'b0);
    push_beat(1, 8'h33, 1'b1);
    push_beat(0, 8'h40, 1'b1);
    push_beat(2, 8'h42, 1'b1);
    expect_beat(2'd1, 1'b0, 8'h31);
    expect_beat(2'd1, 1'b0, 8'h32);
    expect_beat(2'd1, 1'b1, 8'h33);
    expect_beat(2'd2, 1'b1, 8'h42);
    expect_beat(2'd0, 1'b1, 8'h40);
    @(negedge clk);
    chk("lock_busy0", 32'(bus.busy), 32'h0);
    chk("lock_ready0", 32'(bus.in_ready), 32'h2);
    tick();
    @(negedge clk);
    chk("lock_busy1", 32'(bus.busy), 32'h1);
    chk("lock_ready1", 32'(bus.in_ready), 32'h2);
    tick();
    @(negedge clk);
    chk("lock_busy2", 32'(bus.busy), 32'h1);
    tick();
    @(negedge clk);
    chk("lock_busy_end", 32'(bus.busy), 32'h0);
    chk("lock_next_grant", 32'(bus.in_ready), 32'h4);
    wait_done("lock_drain", 20);

    // 4: backpressure for four cycles with a beat held in the output register
    push_beat(3, 8'h50, 1'b0);
    push_beat(3, 8'h51, 1'b0);
    push_beat(3, 8'h52, 1'b1);
    expect_beat(2'd3, 1'b0, 8'h50);
    expect_beat(2'd3, 1'b0, 8'h51);
    expect_beat(2'd3, 1'b1, 8'h52);
    @(negedge clk);
    chk("bp_ready_pre", 32'(bus.in_ready), 32'h8);
    tick();
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'h1);
      chk("bp_out_data", 32'(bus.out_data), 32'h50);
      chk("bp_out_last", 32'(bus.out_last), 32'h0);
      chk("bp_out_ch", 32'(bus.out_ch), 32'h3);
      chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_done("bp_drain", 20);

    // 5: sel moves to ch3 while a ch0 packet is open
    bus.mode = 1'b0;
    bus.sel  = 2'd0;
    push_beat(0, 8'h60, 1'b0);
    push_beat(0, 8'h61, 1'b0);
    push_beat(0, 8'h62, 1'b1);
    push_beat(3, 8'h63, 1'b1);
    expect_beat(2'd0, 1'b0, 8'h60);
    expect_beat(2'd0, 1'b0, 8'h61);
    expect_beat(2'd0, 1'b1, 8'h62);
    expect_beat(2'd3, 1'b1, 8'h63);
    @(negedge clk);
    chk("sel_ready0", 32'(bus.in_ready), 32'h1);
    tick();
    bus.sel = 2'd3;
    @(negedge clk);
    chk("sel_ready1", 32'(bus.in_ready), 32'h1);
    chk("sel_busy1", 32'(bus.busy), 32'h1);
    tick();
    @(negedge clk);
    chk("sel_ready2", 32'(bus.in_ready), 32'h1);
    tick();
    @(negedge clk);
    chk("sel_ready3", 32'(bus.in_ready), 32'h8);
    wait_done("sel_drain", 20);

    // 6: reset during a locked ch2 packet; rr_ptr first parked at ch1
    bus.mode = 1'b1;
    push_beat(1, 8'h6F, 1'b1);
    expect_beat(2'd1, 1'b1, 8'h6F);
    wait_done("park_rr1", 20);
    push_beat(2, 8'h70, 1'b0);
    push_beat(2, 8'h71, 1'b0);
    push_beat(2, 8'h72, 1'b0);
    push_beat(2, 8'h73, 1'b1);
    expect_beat(2'd2, 1'b0, 8'h70);
    @(negedge clk);
    chk("mrst_ready0", 32'(bus.in_ready), 32'h4);
    tick();
    @(negedge clk);
    chk("mrst_busy", 32'(bus.busy), 32'h1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("mrst_busy0", 32'(bus.busy), 32'h0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'h0);
    clear_ch(2);
    push_beat(2, 8'h82, 1'b1);
    push_beat(1, 8'h81, 1'b1);
    push_beat(0, 8'h80, 1'b1);
    expect_beat(2'd0, 1'b1, 8'h80);
    expect_beat(2'd1, 1'b1, 8'h81);
    expect_beat(2'd2, 1'b1, 8'h82);
    tick();
    tick();
    rst_n = 1'b1;
    wait_done("mrst_drain", 20);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
